// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and widths for the two-master SRAM-like bus arbiter.
package sram_bus_arbiter_pkg;

  localparam int unsigned REG_BUS_W = 32;
  localparam int unsigned SEL_W     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  // Command captured from the winning master and replayed to the slave.
  typedef struct packed {
    logic                 wr;
    logic [SEL_W-1:0]     select;
    logic [REG_BUS_W-1:0] addr;
    logic [REG_BUS_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/sram_bus_arbiter_grant_pick.sv
// Combinational winner selection between the instruction and data masters.
module bus_grant_pick
  import sram_bus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic   inst_req,
  input  logic   data_req,
  input  grant_e rr_last,
  output logic   valid,
  output grant_e grant
);

  // Data wins by default; on a tie in round-robin mode the last winner yields.
  always_comb begin
    valid = inst_req | data_req;
    grant = GRANT_DATA;
    if (inst_req && !data_req) begin
      grant = GRANT_INST;
    end else if (inst_req && data_req && ROUND_ROBIN) begin
      grant = (rr_last == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave port between the instruction and data masters,
// one transaction at a time, with registered slave-side command outputs.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_req,
  input  logic                 inst_wr,
  input  logic [SEL_W-1:0]     inst_select,
  input  logic [REG_BUS_W-1:0] inst_addr,
  input  logic [REG_BUS_W-1:0] inst_wdata,
  output logic                 inst_addr_ok,
  output logic                 inst_data_ok,
  output logic [REG_BUS_W-1:0] inst_rdata,
  input  logic                 data_req,
  input  logic                 data_wr,
  input  logic [SEL_W-1:0]     data_select,
  input  logic [REG_BUS_W-1:0] data_addr,
  input  logic [REG_BUS_W-1:0] data_wdata,
  output logic                 data_addr_ok,
  output logic                 data_data_ok,
  output logic [REG_BUS_W-1:0] data_rdata,
  output logic                 req,
  output logic                 wr,
  output logic [SEL_W-1:0]     select,
  output logic [REG_BUS_W-1:0] addr,
  output logic [REG_BUS_W-1:0] wdata,
  input  logic                 addr_ok,
  input  logic                 data_ok,
  input  logic [REG_BUS_W-1:0] rdata
);

  arb_state_e state_q, state_d;
  grant_e     grant_q, grant_d;
  grant_e     rr_last_q, rr_last_d;
  bus_cmd_t   cmd_q, cmd_d;
  logic       req_q, req_d;

  logic       pick_valid;
  grant_e     pick_grant;
  bus_cmd_t   inst_cmd, data_cmd;

  assign inst_cmd = '{wr: inst_wr, select: inst_select, addr: inst_addr, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, select: data_select, addr: data_addr, wdata: data_wdata};

  bus_grant_pick #(
    .ROUND_ROBIN (ROUND_ROBIN != 0)
  ) u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .rr_last  (rr_last_q),
    .valid    (pick_valid),
    .grant    (pick_grant)
  );

  // Next state, next grant and next slave command.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cmd_d     = cmd_q;
    req_d     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_grant;
          rr_last_d = pick_grant;
          cmd_d     = (pick_grant == GRANT_DATA) ? data_cmd : inst_cmd;
          req_d     = 1'b1;
          state_d   = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        req_d = 1'b1;
        if (addr_ok) begin
          req_d   = 1'b0;
          state_d = data_ok ? ARB_IDLE : ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (data_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and registered slave-side outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= GRANT_INST;
      rr_last_q <= GRANT_INST;
      cmd_q     <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cmd_q     <= cmd_d;
      req_q     <= req_d;
    end
  end

  assign req    = req_q;
  assign wr     = cmd_q.wr;
  assign select = cmd_q.select;
  assign addr   = cmd_q.addr;
  assign wdata  = cmd_q.wdata;

  logic in_addr, busy;
  assign in_addr = (state_q == ARB_ADDR);
  assign busy    = (state_q != ARB_IDLE);

  // Route slave handshakes to the granted master only, with no added latency.
  assign inst_addr_ok = in_addr && (grant_q == GRANT_INST) && addr_ok;
  assign data_addr_ok = in_addr && (grant_q == GRANT_DATA) && addr_ok;
  assign inst_data_ok = busy && (grant_q == GRANT_INST) && data_ok;
  assign data_data_ok = busy && (grant_q == GRANT_DATA) && data_ok;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule
